// File: rtl/sample_queue_pkg.sv
// Shared constants, FSM states and pointer helpers for the stereo sample queue.
// Imported by the queue top and its dual-port storage.
package sample_queue_pkg;

    localparam int Q_DEPTH = 1024;
    localparam int N_TAPS  = 1021;
    localparam int SMPL_W  = 16;
    localparam int PAIR_W  = 2 * SMPL_W;
    localparam int PTR_W   = $clog2(Q_DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;

    localparam ptr_t PTR_ONE  = ptr_t'(1);
    localparam ptr_t TAPS     = ptr_t'(N_TAPS);
    localparam ptr_t LAST_TAP = ptr_t'(N_TAPS - 1);

    typedef enum logic [1:0] {
        FILL,
        WAIT,
        READ
    } state_t;

    // Oldest slot of a burst whose newest sample sits just below ptr.
    function automatic ptr_t burst_base(input ptr_t ptr);
        return ptr - TAPS;
    endfunction

endpackage

// File: rtl/sample_queue_ram.sv
// 1024 x 32 storage for packed {left,right} pairs.
// One write port, one registered read port (1-cycle latency).
module dualPort1024x32
    import sample_queue_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [PAIR_W-1:0] wdata,
    input  logic              re,
    input  logic [PTR_W-1:0]  raddr,
    output logic [PAIR_W-1:0] rdata
);

    logic [PAIR_W-1:0] mem [Q_DEPTH];

    // Write port: contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: registered output.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sample_queue.sv
// Circular stereo sample queue that replays the newest 1021 pairs as a
// burst, oldest first, each time a new pair arrives once the queue is full.
module sample_queue
    import sample_queue_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wrt_smpl,
    input  logic signed [SMPL_W-1:0] lft_smpl,
    input  logic signed [SMPL_W-1:0] rght_smpl,
    output logic                     sequencing,
    output logic signed [SMPL_W-1:0] lft_out,
    output logic signed [SMPL_W-1:0] rght_out
);

    state_t state;
    state_t state_nxt;

    ptr_t new_ptr;
    ptr_t new_ptr_nxt;
    ptr_t fill_cnt;
    ptr_t fill_cnt_nxt;
    ptr_t rd_ptr;
    ptr_t rd_cnt;
    ptr_t rd_start;

    logic pending;
    logic pending_nxt;
    logic start;
    logic rd_en;
    logic rd_last;
    logic rd_vld;

    logic [PAIR_W-1:0] rd_data;

    // Write pointer, saturating fill count and burst base address.
    always_comb begin
        new_ptr_nxt  = new_ptr;
        fill_cnt_nxt = fill_cnt;
        if (wrt_smpl) begin
            new_ptr_nxt = new_ptr + PTR_ONE;
            if (fill_cnt != TAPS) begin
                fill_cnt_nxt = fill_cnt + PTR_ONE;
            end
        end
        rd_start = burst_base(new_ptr_nxt);
        rd_en    = (state == READ);
        rd_last  = rd_en && (rd_cnt == LAST_TAP);
    end

    // Next state, burst start and pending-burst bookkeeping.
    always_comb begin
        state_nxt   = state;
        start       = 1'b0;
        pending_nxt = pending;
        unique case (state)
            FILL: begin
                if (wrt_smpl && fill_cnt_nxt == TAPS) begin
                    start     = 1'b1;
                    state_nxt = READ;
                end
            end
            WAIT: begin
                if (wrt_smpl || pending) begin
                    start       = 1'b1;
                    pending_nxt = 1'b0;
                    state_nxt   = READ;
                end
            end
            READ: begin
                if (wrt_smpl) begin
                    pending_nxt = 1'b1;
                end
                if (rd_last) begin
                    state_nxt = WAIT;
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    // Control registers; a burst end always passes through WAIT so the
    // output strobe gets a low cycle before the next burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            new_ptr  <= '0;
            fill_cnt <= '0;
            pending  <= 1'b0;
            rd_ptr   <= '0;
            rd_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            new_ptr  <= new_ptr_nxt;
            fill_cnt <= fill_cnt_nxt;
            pending  <= pending_nxt;
            if (start) begin
                rd_ptr <= rd_start;
                rd_cnt <= '0;
            end else if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                rd_cnt <= rd_cnt + PTR_ONE;
            end
        end
    end

    // Output stage: align the strobe with RAM latency and zero idle slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld     <= 1'b0;
            sequencing <= 1'b0;
            lft_out    <= '0;
            rght_out   <= '0;
        end else begin
            rd_vld     <= rd_en;
            sequencing <= rd_vld;
            if (rd_vld) begin
                lft_out  <= rd_data[PAIR_W-1 -: SMPL_W];
                rght_out <= rd_data[SMPL_W-1:0];
            end else begin
                lft_out  <= '0;
                rght_out <= '0;
            end
        end
    end

    dualPort1024x32 u_ram (
        .clk   (clk),
        .we    (wrt_smpl),
        .waddr (new_ptr),
        .wdata ({lft_smpl, rght_smpl}),
        .re    (rd_en),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_sample_queue.sv
// Bench for sample_queue: directed fill/steady/mid-burst/reset scenarios
// then random traffic, all checked against a history-window model.
module tb_sample_queue;
    import sample_queue_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     wrt_smpl;
    logic signed [SMPL_W-1:0] lft_smpl;
    logic signed [SMPL_W-1:0] rght_smpl;
    logic                     sequencing;
    logic signed [SMPL_W-1:0] lft_out;
    logic signed [SMPL_W-1:0] rght_out;

    always #5 clk = ~clk;

    sample_queue dut (
        .clk        (clk),
        .rst        (rst),
        .wrt_smpl   (wrt_smpl),
        .lft_smpl   (lft_smpl),
        .rght_smpl  (rght_smpl),
        .sequencing (sequencing),
        .lft_out    (lft_out),
        .rght_out   (rght_out)
    );

    typedef struct packed {
        logic signed [SMPL_W-1:0] l;
        logic signed [SMPL_W-1:0] r;
    } pair_t;

    pair_t hist[$];
    pair_t snap[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int cnt;
    int rd_end;
    int win_from;
    int win_to;
    int wr_since;
    int run_len = 0;
    bit pend;

    task automatic chk(input string tag,
                       input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        snap.delete();
        cnt      = 0;
        rd_end   = -10;
        win_from = -10;
        win_to   = -20;
        wr_since = 0;
        pend     = 1'b0;
    endtask

    // Burst = newest N_TAPS pairs at the trigger edge, shown on
    // cycles trigger+2 .. trigger+N_TAPS+1.
    task automatic model_edge(input bit w,
                              input logic signed [SMPL_W-1:0] l,
                              input logic signed [SMPL_W-1:0] r);
        bit trig;
        trig = 1'b0;
        if (w) begin
            hist.push_back({l, r});
            if (hist.size() > N_TAPS) begin
                void'(hist.pop_front());
            end
            if (cnt < N_TAPS) begin
                cnt++;
            end
            wr_since++;
            if (cnt == N_TAPS) begin
                if (cyc <= rd_end) begin
                    pend = 1'b1;
                end else begin
                    trig = 1'b1;
                end
            end
        end
        if (pend && cyc == rd_end + 1) begin
            trig = 1'b1;
        end
        if (trig) begin
            pend     = 1'b0;
            snap     = hist;
            win_from = cyc + 2;
            win_to   = cyc + N_TAPS + 1;
            rd_end   = cyc + N_TAPS;
            wr_since = 0;
        end
    endtask

    task automatic check_out();
        bit hi;
        hi = (cyc >= win_from) && (cyc <= win_to);
        chk("sequencing", sequencing, hi);
        if (hi) begin
            chk("lft_out", lft_out, snap[cyc - win_from].l);
            chk("rght_out", rght_out, snap[cyc - win_from].r);
        end else begin
            chk("lft_out_idle", lft_out, 0);
            chk("rght_out_idle", rght_out, 0);
        end
        if (sequencing === 1'b1) begin
            run_len++;
        end else begin
            if (run_len != 0) begin
                chk("burst_len", run_len, N_TAPS);
            end
            run_len = 0;
        end
    endtask

    task automatic step(input bit r, input bit w, input int l, input int rr);
        @(negedge clk);
        rst       = r;
        wrt_smpl  = w;
        lft_smpl  = w ? SMPL_W'(l) : '0;
        rght_smpl = w ? SMPL_W'(rr) : '0;
        @(posedge clk);
        cyc++;
        if (r) begin
            model_reset();
            run_len = 0;
        end
        #1;
        check_out();
        if (!r) begin
            model_edge(w, lft_smpl, rght_smpl);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 0, 0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        wrt_smpl  = 1'b0;
        lft_smpl  = '0;
        rght_smpl = '0;
        model_reset();

        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 0, 0);
        end

        // Fill 1..1021, then a write mid-burst queues one more burst.
        for (int k = 1; k <= N_TAPS; k++) begin
            step(1'b0, 1'b1, k, -k);
        end
        idle(500);
        step(1'b0, 1'b1, 1022, -1022);
        idle(2100);

        // Steady state: isolated writes.
        for (int k = 1023; k <= 1024; k++) begin
            step(1'b0, 1'b1, k, -k);
            idle(2000);
        end

        // Back-to-back and pending writes across the pointer wrap.
        step(1'b0, 1'b1, 1025, -1025);
        idle(10);
        step(1'b0, 1'b1, 1026, -1026);
        step(1'b0, 1'b1, 1027, -1027);
        idle(2100);

        // Reset mid-burst, then a fresh fill is required.
        step(1'b0, 1'b1, 1028, -1028);
        idle(300);
        step(1'b1, 1'b0, 0, 0);
        for (int k = 1; k < N_TAPS; k++) begin
            step(1'b0, 1'b1, 3000 + k, -3000 - k);
        end
        idle(1100);
        step(1'b0, 1'b1, 4021, -4021);
        idle(1100);

        // Random traffic, at most three writes per burst.
        for (int i = 0; i < 30000; i++) begin
            bit r;
            bit w;
            r = ($urandom_range(0, 9999) == 0);
            if (cnt < N_TAPS) begin
                w = ($urandom_range(0, 3) != 0);
            end else begin
                w = (wr_since < 3) && ($urandom_range(0, 199) == 0);
            end
            step(r, w && !r, int'($urandom), int'($urandom));
        end
        idle(2100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
